ram_sp_arbiter: RTL and testbench
=================================

// Module: ram_sp_arbiter
// PURPOSE
//  Upstream front end for the single-port RAM (ram_sp). Merges an independent write
//  request port and read request port onto the single cen/wen/addr/din interface.
//  Round-robin arbitration on conflict; returns read data on a valid/ready response port.
//  Sustains one RAM access per cycle.
// PARAMETERS
//  DATA_WIDTH  32  data width; must match ram_sp DATA_WIDTH
//  DEPTH       16  RAM depth; ADDR_WIDTH = $clog2(DEPTH) (localparam)
// PORTS
//  clock      in   1           single clock, rising edge
//  reset      in   1           synchronous, active-high
//  wr_valid   in   1           write request valid
//  wr_ready   out  1           write request accepted when wr_valid & wr_ready
//  wr_addr    in   ADDR_WIDTH  write address
//  wr_data    in   DATA_WIDTH  write data
//  rd_valid   in   1           read request valid
//  rd_ready   out  1           read request accepted when rd_valid & rd_ready
//  rd_addr    in   ADDR_WIDTH  read address
//  rsp_valid  out  1           read response valid
//  rsp_ready  in   1           read response consumed when rsp_valid & rsp_ready
//  rsp_data   out  DATA_WIDTH  read response data (= ram_dout)
//  ram_cen    out  1           to ram_sp cen
//  ram_wen    out  1           to ram_sp wen (1 = write)
//  ram_addr   out  ADDR_WIDTH  to ram_sp addr
//  ram_din    out  DATA_WIDTH  to ram_sp din
//  ram_dout   in   DATA_WIDTH  from ram_sp dout
// BEHAVIOUR
//  - Reset values: rsp_valid=0, last_grant=READ; combinational outputs follow from these.
//  - rsp_slot_free = !rsp_valid | rsp_ready.
//  - rd_eligible = rd_valid & rsp_slot_free. wr_eligible = wr_valid.
//  - Grant (combinational, same cycle):
//    - Only one eligible: grant it.
//    - Both eligible: grant the type opposite to last_grant.
//    - Neither: no grant; ram_cen=0.
//  - wr_ready = grant==WRITE. rd_ready = grant==READ.
//    - wr_ready and rd_ready are never high together.
//    - wr_ready does not depend on rsp_ready.
//  - RAM outputs (combinational from the grant):
//    - ram_cen = any grant. ram_wen = (grant==WRITE).
//    - ram_addr = granted port address. ram_din = wr_data.
//    - When idle: ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0.
//  - last_grant: registered on every granted cycle to the granted type; unchanged when idle.
//  - Read latency:
//    - Read accepted in cycle N -> rsp_valid=1 from cycle N+1, rsp_data=ram_dout.
//    - rsp_valid stays high, and rsp_data stable, until rsp_valid & rsp_ready.
//    - Stability holds because ram_sp holds dout across writes and no new read issues
//      while the slot is held.
//  - Response handshake and back-to-back reads:
//    - Response consumed in cycle M and new read accepted in M: rsp_valid stays 1
//      and rsp_data updates at M+1. This gives full throughput.
//    - Consumed with no new read: rsp_valid=0 at M+1.
//  - Backpressure: while rsp_valid & !rsp_ready, reads stall and writes proceed every
//    cycle. last_grant goes to WRITE on each such write.
//  - Ordering:
//    - Within a port, requests are in order.
//    - Across ports, order is the grant order.
//    - A read granted after a write to the same address returns the new data.
//    - A read granted before it returns the old data.
//  - Reset mid-operation: a pending response is dropped (rsp_valid=0 next cycle).
//    No RAM access is issued in a cycle where reset=1 (ready outputs forced 0, ram_cen=0).
//  - Out-of-range addresses (DEPTH not a power of 2): undefined; not checked.
// TESTING
//  1. Reset held with wr_valid=rd_valid=1 -> ram_cen=0, wr_ready=rd_ready=0, rsp_valid=0;
//     release -> first conflict grants WRITE.
//  2. Write addr3=0xDEADBEEF, then read addr3 with rsp_ready=1 -> rsp_valid one cycle
//     after rd accept, rsp_data=0xDEADBEEF.
//  3. wr_valid and rd_valid held high for 6 cycles, rsp_ready=1 -> grants alternate
//     W,R,W,R,W,R; 3 writes and 3 responses.
//  4. 4 back-to-back reads (addr0..3 preloaded 0x10..0x13), rsp_ready=1 -> rsp_valid high
//     4 consecutive cycles with data 0x10..0x13.
//  5. Read addr1 with rsp_ready=0 for 5 cycles while writing addr1=0x55 ->
//     - rsp_data holds the old value throughout.
//     - rd_ready=0 for a second read while blocked.
//     - Writes accepted every cycle.
//  6. Reset asserted with rsp_valid=1 and requests pending -> rsp_valid=0 the next cycle;
//     no RAM write occurs during reset.

Source files
------------

// File: rtl/ram_sp_arbiter.sv
// Front end for the single-port RAM. A write request port and a read request
// port share one cen/wen/addr/din interface, with round-robin arbitration when
// both compete. Read data returns on a one-entry valid/ready response slot that
// holds ram_dout until it is consumed. One RAM access can issue every cycle.
//
// Handshake rule for every port: a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. A producer holds its payload
// stable while valid is high and ready is low. ready is not registered. wr_ready
// and rd_ready are decided in the same cycle from the current requests and state.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // Grant for the current cycle. It is combinational and never stored.
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_WRITE = 2'd1,
    GRANT_READ  = 2'd2
  } grant_t;

  // Type of the most recent granted access. Used to break ties.
  typedef enum logic {
    LAST_READ  = 1'b0,
    LAST_WRITE = 1'b1
  } last_t;

  // All registered state is kept in one place so it is easy to observe.
  typedef struct packed {
    last_t last_grant;
    logic  rsp_valid;
  } arb_state_t;

  localparam arb_state_t STATE_RESET = '{last_grant: LAST_READ, rsp_valid: 1'b0};

  arb_state_t state_q;
  arb_state_t state_d;
  grant_t     grant;

  logic rsp_slot_free;
  logic rd_eligible;
  logic wr_eligible;
  logic rsp_taken;

  // The response slot can accept a new read if it is empty, or if it is being
  // drained in this same cycle. This allows back-to-back reads at full rate.
  assign rsp_slot_free = !state_q.rsp_valid || rsp_ready;
  assign rd_eligible   = rd_valid && rsp_slot_free;
  assign wr_eligible   = wr_valid;
  assign rsp_taken     = state_q.rsp_valid && rsp_ready;

  // Arbitration. A lone eligible request wins. When both requests are
  // eligible, the type that did not win last time wins now. No request is
  // granted while reset is high.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (wr_eligible && rd_eligible) begin
        grant = (state_q.last_grant == LAST_READ) ? GRANT_WRITE : GRANT_READ;
      end else if (wr_eligible) begin
        grant = GRANT_WRITE;
      end else if (rd_eligible) begin
        grant = GRANT_READ;
      end
    end
  end

  // Ready signals and the RAM command follow directly from the grant.
  // When no request is granted, all RAM outputs are driven to zero.
  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (grant)
      GRANT_WRITE: begin
        wr_ready = 1'b1;
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = wr_addr;
        ram_din  = wr_data;
      end
      GRANT_READ: begin
        rd_ready = 1'b1;
        ram_cen  = 1'b1;
        ram_addr = rd_addr;
      end
      default: begin
      end
    endcase
  end

  // Next-state logic. A granted read fills the response slot on the next
  // cycle. A drained slot with no new read becomes empty. Every grant records
  // its type for the next tie-break.
  always_comb begin
    state_d = state_q;
    if (grant == GRANT_READ) begin
      state_d.rsp_valid = 1'b1;
    end else if (rsp_taken) begin
      state_d.rsp_valid = 1'b0;
    end
    if (grant == GRANT_WRITE) begin
      state_d.last_grant = LAST_WRITE;
    end else if (grant == GRANT_READ) begin
      state_d.last_grant = LAST_READ;
    end
  end

  // State register. Reset is synchronous and drops any pending response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // The RAM holds dout until its next read. No read issues while the slot is
  // occupied, so the response data can be taken straight from the RAM.
  assign rsp_valid = state_q.rsp_valid;
  assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter. It includes a behavioural single-port RAM. The bench
// first applies a table of directed vectors and a few hand-written sequences.
// It then runs randomized traffic and compares the DUT against a reference
// model built from a shadow memory and a queue of expected responses.
module tb_ram_sp_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int failures = 0;

  ram_sp_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- single-port RAM model ----------------
  // dout changes only on a read. Writes leave dout unchanged.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    if (ram_cen) begin
      if (ram_wen) ram_mem[ram_addr] <= ram_din;
      else         ram_dout <= ram_mem[ram_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs are applied 1 ns after the rising edge. Outputs are checked at the
  // following falling edge.
  task automatic drive(input logic rst, input logic wv, input logic rv, input logic rr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra);
    @(posedge clock);
    #1;
    reset = rst; wr_valid = wv; rd_valid = rv; rsp_ready = rr;
    wr_addr = wa; wr_data = wd; rd_addr = ra;
    @(negedge clock);
  endtask

  task automatic check_all(input string tag, input logic ewr, input logic erd,
                           input logic ecen, input logic ewen, input logic [AW-1:0] eaddr,
                           input logic [DW-1:0] edin, input logic erv, input logic [DW-1:0] edata);
    check({tag, ".wr_ready"},  DW'(wr_ready),  DW'(ewr));
    check({tag, ".rd_ready"},  DW'(rd_ready),  DW'(erd));
    check({tag, ".ram_cen"},   DW'(ram_cen),   DW'(ecen));
    check({tag, ".ram_wen"},   DW'(ram_wen),   DW'(ewen));
    check({tag, ".ram_addr"},  DW'(ram_addr),  DW'(eaddr));
    check({tag, ".ram_din"},   ram_din,        edin);
    check({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(erv));
    if (erv) check({tag, ".rsp_data"}, rsp_data, edata);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst, wv, rv, rr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic          ewr, erd, ecen, ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    logic          erv;
    logic [DW-1:0] edata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, wv, rv, rr, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                              input logic ewr, erd, ecen, ewen, input logic [AW-1:0] eaddr,
                              input logic [DW-1:0] edin, input logic erv,
                              input logic [DW-1:0] edata);
    vec_t v;
    v.rst = rst; v.wv = wv; v.rv = rv; v.rr = rr; v.wa = wa; v.wd = wd; v.ra = ra;
    v.ewr = ewr; v.erd = erd; v.ecen = ecen; v.ewen = ewen; v.eaddr = eaddr;
    v.edin = edin; v.erv = erv; v.edata = edata;
    return v;
  endfunction

  // ---------------- reference model state ----------------
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            m_last_write;

  // ---------------- main sequence ----------------
  initial begin
    logic          r_rst, r_wv, r_rv, r_rr;
    logic [AW-1:0] r_wa, r_ra;
    logic [DW-1:0] r_wd;
    bit            g_wr, g_rd, rd_el;

    reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(posedge clock);

    // Rows 0-3: reset and the first conflict, then a write and a read of 0xDEADBEEF.
    vecs[0]  = mk(1,1,1,1, 3, 32'hDEADBEEF, 3,  0,0,0,0, 0, 0, 0, 0);
    vecs[1]  = mk(0,1,1,1, 3, 32'hDEADBEEF, 3,  1,0,1,1, 3, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(0,0,1,1, 0, 0, 3,             0,1,1,0, 3, 0, 0, 0);
    vecs[3]  = mk(0,0,0,1, 0, 0, 0,             0,0,0,0, 0, 0, 1, 32'hDEADBEEF);
    // Rows 4-13: preload 0x10..0x13, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      vecs[4+i] = mk(0,1,0,1, AW'(i), DW'(32'h10 + i), 0, 1,0,1,1, AW'(i), DW'(32'h10 + i), 0, 0);
      vecs[8+i] = mk(0,0,1,1, 0, 0, AW'(i), 0,1,1,0, AW'(i), 0, (i > 0), DW'(32'h10 + i - 1));
    end
    vecs[12] = mk(0,0,0,1, 0, 0, 0,  0,0,0,0, 0, 0, 1, 32'h13);
    vecs[13] = mk(0,0,0,1, 0, 0, 0,  0,0,0,0, 0, 0, 0, 0);
    // Rows 14-20: both requests held high, so grants alternate W,R,W,R,W,R.
    vecs[14] = mk(0,1,1,1, 8,  32'hA0, 0,  1,0,1,1, 8,  32'hA0, 0, 0);
    vecs[15] = mk(0,1,1,1, 9,  32'hA1, 0,  0,1,1,0, 0,  0,      0, 0);
    vecs[16] = mk(0,1,1,1, 9,  32'hA1, 1,  1,0,1,1, 9,  32'hA1, 1, 32'h10);
    vecs[17] = mk(0,1,1,1, 10, 32'hA2, 1,  0,1,1,0, 1,  0,      0, 0);
    vecs[18] = mk(0,1,1,1, 10, 32'hA2, 2,  1,0,1,1, 10, 32'hA2, 1, 32'h11);
    vecs[19] = mk(0,1,1,1, 11, 32'hA3, 2,  0,1,1,0, 2,  0,      0, 0);
    vecs[20] = mk(0,0,0,1, 0, 0, 0,        0,0,0,0, 0,  0,      1, 32'h12);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].wv, vecs[i].rv, vecs[i].rr, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      check_all($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].erd, vecs[i].ecen, vecs[i].ewen,
                vecs[i].eaddr, vecs[i].edin, vecs[i].erv, vecs[i].edata);
    end

    // Backpressure: read addr1 (0x11) is held while addr1 is rewritten to 0x55.
    drive(0, 0, 1, 0, 0, 0, 1);
    check_all("bp.accept", 0, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 1, 32'h55, 1);
      check_all($sformatf("bp.hold%0d", i), 1, 0, 1, 1, 1, 32'h55, 1, 32'h11);
    end
    drive(0, 0, 1, 1, 0, 0, 1);
    check_all("bp.release", 0, 1, 1, 0, 1, 0, 1, 32'h11);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_all("bp.newdata", 0, 0, 0, 0, 0, 0, 1, 32'h55);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_all("bp.drained", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a response is pending and both requests are active.
    drive(0, 0, 1, 0, 0, 0, 0);
    check_all("rst.read", 0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 32'hBAD, 0);
    check_all("rst.during", 0, 0, 0, 0, 0, 0, 1, 32'h10);
    drive(0, 1, 1, 0, 0, 32'hBAD, 0);
    check_all("rst.after", 1, 0, 1, 1, 0, 32'hBAD, 0, 0);
    check("rst.no_ram_write", ram_mem[0], 32'h10);
    drive(0, 0, 0, 1, 0, 0, 0);

    // Preload every address through the DUT so the model knows the memory contents.
    for (int i = 0; i < DEPTH; i++) begin
      r_wd = $urandom;
      drive(0, 1, 0, 1, AW'(i), r_wd, 0);
      check($sformatf("preload%0d.wr_ready", i), DW'(wr_ready), 1);
      model_mem[i] = r_wd;
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    exp_q.delete();
    m_last_write = 1'b1;

    // Randomized traffic compared against the reference model.
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_wv  = ($urandom_range(0, 9) < 6);
      r_rv  = ($urandom_range(0, 9) < 6);
      r_rr  = ($urandom_range(0, 9) < 7);
      r_wa  = AW'($urandom_range(0, DEPTH - 1));
      r_ra  = AW'($urandom_range(0, DEPTH - 1));
      r_wd  = $urandom;
      drive(r_rst, r_wv, r_rv, r_rr, r_wa, r_wd, r_ra);

      rd_el = r_rv && (exp_q.size() == 0 || r_rr);
      g_wr = 1'b0; g_rd = 1'b0;
      if (!r_rst) begin
        if (r_wv && rd_el) begin
          g_wr = !m_last_write;
          g_rd = m_last_write;
        end else begin
          g_wr = r_wv;
          g_rd = rd_el;
        end
      end
      check_all($sformatf("rand%0d", c), g_wr, g_rd, g_wr | g_rd, g_wr,
                g_wr ? r_wa : (g_rd ? r_ra : '0), g_wr ? r_wd : '0,
                exp_q.size() > 0, (exp_q.size() > 0) ? exp_q[0] : '0);

      if (r_rst) begin
        exp_q.delete();
        m_last_write = 1'b0;
      end else begin
        if (exp_q.size() > 0 && r_rr) void'(exp_q.pop_front());
        if (g_rd) begin
          exp_q.push_back(model_mem[r_ra]);
          m_last_write = 1'b0;
        end
        if (g_wr) begin
          model_mem[r_wa] = r_wd;
          m_last_write = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
